// File: rtl/uart_tx_frac_if.sv
// AXI-Stream beat channel feeding the fractional-baud UART transmitter.
interface uart_tx_frac_if #(
    parameter int MAX_WORD_SIZE = 9
);
    logic [MAX_WORD_SIZE-1:0] tdata;
    logic                     tvalid;
    logic                     tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_frac.sv
// UART transmitter with a double-buffered AXI-Stream input, a fractional baud divider,
// runtime word/parity/stop configuration and line-break generation.
module uart_tx_frac #(
    parameter int MAX_WORD_SIZE   = 9,
    parameter int RESET_PRESCALER = 12
) (
    input  logic                 aclk,
    input  logic                 rst,
    uart_tx_frac_if.slave        s_axis,
    output logic                 txd,
    input  logic                 ctsn,
    input  logic                 break_req,
    output logic                 break_active,
    output logic                 busy,
    output logic                 frame_done,
    input  logic [15:0]          prescaler_config,
    input  logic [3:0]           frac_config,
    input  logic [3:0]           word_size_config,
    input  logic [2:0]           parity_config,
    input  logic [1:0]           stop_bits_config
);
    localparam int         W        = MAX_WORD_SIZE;
    localparam logic [3:0] WS_MAX   = 4'(MAX_WORD_SIZE);
    localparam logic [1:0] STOP_ONE = 2'd0;
    localparam logic [1:0] STOP_TWO = 2'd1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

    function automatic logic [15:0] sat_prescaler(input logic [15:0] p);
        return (p < 16'd2) ? 16'd2 : p;
    endfunction

    function automatic logic [3:0] sat_word_size(input logic [3:0] w);
        if (w < 4'd5)        return 4'd5;
        else if (w > WS_MAX) return WS_MAX;
        else                 return w;
    endfunction

    function automatic logic [W-1:0] word_mask(input logic [3:0] w);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (i < int'(w));
        return m;
    endfunction

    function automatic logic parity_bit(input logic [2:0] mode, input logic [W-1:0] d);
        case (mode)
            3'd1:    return ^d;
            3'd2:    return ~^d;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    state_t       state_q, state_d;
    logic         txd_q, txd_d;
    logic         hold_valid_q, hold_valid_d;
    logic [W-1:0] hold_q, hold_d;
    logic [W-1:0] shift_q, shift_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [3:0]   acc_q, acc_d;
    logic [3:0]   bit_idx_q, bit_idx_d;
    logic [1:0]   stop_ph_q, stop_ph_d;
    logic         brk_stop_q, brk_stop_d;
    logic         frame_done_q, frame_done_d;
    logic         par_bit_q, par_bit_d;
    logic [15:0]  cfg_presc_q, cfg_presc_d;
    logic [3:0]   cfg_frac_q, cfg_frac_d;
    logic [3:0]   cfg_ws_q, cfg_ws_d;
    logic         cfg_par_en_q, cfg_par_en_d;
    logic [1:0]   cfg_stop_q, cfg_stop_d;

    logic         accept, load, bit_end, bit_start, half_start, carry, last_stop, stop_last_d;
    logic [3:0]   acc_base, acc_sum;
    logic [16:0]  full_m1;
    logic [W-1:0] load_word;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        bit_idx_d    = bit_idx_q;
        stop_ph_d    = stop_ph_q;
        brk_stop_d   = brk_stop_q;
        par_bit_d    = par_bit_q;
        cfg_presc_d  = cfg_presc_q;
        cfg_frac_d   = cfg_frac_q;
        cfg_ws_d     = cfg_ws_q;
        cfg_par_en_d = cfg_par_en_q;
        cfg_stop_d   = cfg_stop_q;
        load         = 1'b0;
        bit_start    = 1'b0;
        half_start   = 1'b0;
        accept       = s_axis.tvalid & ~hold_valid_q;
        bit_end      = (cnt_q == 16'd0);
        last_stop    = brk_stop_q | (cfg_stop_q == STOP_ONE) | (stop_ph_q == 2'd2) |
                       ((cfg_stop_q == STOP_TWO) & (stop_ph_q == 2'd1));
        if (accept) hold_d = s_axis.tdata;

        case (state_q)
            IDLE: begin
                if (break_req) begin
                    state_d   = BREAK;
                    bit_start = 1'b1;
                end else if (hold_valid_q & ~ctsn) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 4'd0;
                    bit_start = 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_start = 1'b1;
                    if (bit_idx_q == cfg_ws_q - 4'd1) begin
                        state_d   = cfg_par_en_q ? PAR : STOP;
                        stop_ph_d = 2'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d   = STOP;
                    stop_ph_d = 2'd0;
                    bit_start = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        brk_stop_d = 1'b0;
                        // A pending word chains straight into its start bit with no idle cycle.
                        if (~brk_stop_q & ~break_req & hold_valid_q & ~ctsn) load = 1'b1;
                        else state_d = IDLE;
                    end else if (cfg_stop_q == STOP_TWO) begin
                        stop_ph_d = 2'd1;
                        bit_start = 1'b1;
                    end else begin
                        stop_ph_d  = 2'd2;
                        half_start = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (bit_end & ~break_req) begin
                    state_d    = STOP;
                    brk_stop_d = 1'b1;
                    stop_ph_d  = 2'd0;
                    bit_start  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        load_word = hold_q & word_mask(sat_word_size(word_size_config));
        if (load) begin
            state_d      = START;
            shift_d      = load_word;
            par_bit_d    = parity_bit(parity_config, load_word);
            cfg_presc_d  = sat_prescaler(prescaler_config);
            cfg_frac_d   = frac_config;
            cfg_ws_d     = sat_word_size(word_size_config);
            cfg_par_en_d = (parity_config >= 3'd1) & (parity_config <= 3'd4);
            cfg_stop_d   = (stop_bits_config == 2'd3) ? STOP_ONE : stop_bits_config;
            bit_start    = 1'b1;
        end

        // Fractional divider: the accumulator carry stretches a bit by one cycle.
        acc_base         = load ? 4'd0 : acc_q;
        {carry, acc_sum} = {1'b0, acc_base} + {1'b0, cfg_frac_d};
        full_m1          = {1'b0, cfg_presc_d} + {16'd0, carry} - 17'd1;
        if (bit_start) begin
            cnt_d = full_m1[15:0];
            acc_d = acc_sum;
        end else if (half_start) begin
            cnt_d = (cfg_presc_d >> 1) - 16'd1;
        end else if (!bit_end) begin
            cnt_d = cnt_q - 16'd1;
        end

        hold_valid_d = load ? 1'b0 : (hold_valid_q | accept);
        stop_last_d  = brk_stop_d | (cfg_stop_d == STOP_ONE) | (stop_ph_d == 2'd2) |
                       ((cfg_stop_d == STOP_TWO) & (stop_ph_d == 2'd1));
        frame_done_d = (state_d == STOP) & ~brk_stop_d & (cnt_d == 16'd0) & stop_last_d;

        case (state_d)
            START, BREAK: txd_d = 1'b0;
            DATA:         txd_d = shift_d[0];
            PAR:          txd_d = par_bit_d;
            default:      txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            txd_q        <= 1'b1;
            hold_valid_q <= 1'b0;
            cnt_q        <= 16'd0;
            acc_q        <= 4'd0;
            bit_idx_q    <= 4'd0;
            stop_ph_q    <= 2'd0;
            brk_stop_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_presc_q  <= 16'(RESET_PRESCALER);
            cfg_frac_q   <= 4'd0;
            cfg_ws_q     <= 4'd8;
            cfg_par_en_q <= 1'b0;
            cfg_stop_q   <= STOP_ONE;
        end else begin
            state_q      <= state_d;
            txd_q        <= txd_d;
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            bit_idx_q    <= bit_idx_d;
            stop_ph_q    <= stop_ph_d;
            brk_stop_q   <= brk_stop_d;
            frame_done_q <= frame_done_d;
            cfg_presc_q  <= cfg_presc_d;
            cfg_frac_q   <= cfg_frac_d;
            cfg_ws_q     <= cfg_ws_d;
            cfg_par_en_q <= cfg_par_en_d;
            cfg_stop_q   <= cfg_stop_d;
        end
    end

    // Word storage carries no reset; hold_valid_q qualifies its contents.
    always_ff @(posedge aclk) begin
        hold_q    <= hold_d;
        shift_q   <= shift_d;
        par_bit_q <= par_bit_d;
    end

    assign txd           = txd_q;
    assign frame_done    = frame_done_q;
    assign busy          = (state_q != IDLE);
    assign break_active  = (state_q == BREAK);
    assign s_axis.tready = ~hold_valid_q;
endmodule

// File: tb/tb_uart_tx_frac.sv
// Directed bench for uart_tx_frac: table of single frames plus hand-written
// back-to-back, flow-control, break and reset sequences.
module tb_uart_tx_frac;
    logic        aclk = 1'b0;
    logic        rst;
    logic        txd, ctsn, break_req, break_active, busy, frame_done;
    logic [15:0] prescaler_config;
    logic [3:0]  frac_config, word_size_config;
    logic [2:0]  parity_config;
    logic [1:0]  stop_bits_config;

    int checks   = 0;
    int failures = 0;

    uart_tx_frac_if #(.MAX_WORD_SIZE(9)) s_axis_if ();

    uart_tx_frac #(.MAX_WORD_SIZE(9), .RESET_PRESCALER(12)) dut (
        .aclk(aclk), .rst(rst), .s_axis(s_axis_if), .txd(txd), .ctsn(ctsn),
        .break_req(break_req), .break_active(break_active), .busy(busy),
        .frame_done(frame_done), .prescaler_config(prescaler_config),
        .frac_config(frac_config), .word_size_config(word_size_config),
        .parity_config(parity_config), .stop_bits_config(stop_bits_config)
    );

    always #5 aclk = ~aclk;

    // lev: txd level of each bit slot; plus: slots lengthened by one cycle.
    typedef struct {
        logic [15:0] p;
        logic [3:0]  f;
        logic [3:0]  ws;
        logic [2:0]  par;
        logic [1:0]  stop;
        logic [8:0]  data;
        int          nbits;
        logic [15:0] lev;
        logic [15:0] plus;
        int          blen;
        int          last_len;
        int          exp_len;
    } vec_t;

    vec_t vecs[9];
    vec_t vb2b, vcts;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] build_wave(input vec_t v);
        logic [63:0] w;
        int pos, len;
        w   = '0;
        pos = 0;
        for (int b = 0; b < v.nbits; b++) begin
            len = (b == v.nbits - 1 && v.last_len != 0) ? v.last_len : v.blen + int'(v.plus[b]);
            for (int c = 0; c < len; c++) begin
                if (pos < 64) w[pos] = v.lev[b];
                pos++;
            end
        end
        return w;
    endfunction

    task automatic set_cfg(input vec_t v);
        prescaler_config = v.p;
        frac_config      = v.f;
        word_size_config = v.ws;
        parity_config    = v.par;
        stop_bits_config = v.stop;
    endtask

    task automatic send(input logic [8:0] d);
        s_axis_if.tdata  = d;
        s_axis_if.tvalid = 1'b1;
        tick();
        s_axis_if.tvalid = 1'b0;
    endtask

    task automatic capture(input int n, output logic [63:0] w, output logic [63:0] tr,
                           output int fd_at, output int fd_cnt, output logic busy_ok);
        w = '0; tr = '0; fd_at = -1; fd_cnt = 0; busy_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            w[i]  = txd;
            tr[i] = s_axis_if.tready;
            if (frame_done) begin
                fd_cnt++;
                if (fd_at < 0) fd_at = i + 1;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        logic [63:0]  w, tr, wa, tra;
        logic [127:0] a_txd, e_txd, a_brk, e_brk, a_busy, e_busy, a_fd, e_fd;
        logic         bz, a1_txd, a1_tr, a2_txd, a2_tr, stayed_idle;
        int           fd_at, fd_cnt;

        vecs[0] = '{16'd4, 4'd0, 4'd8, 3'd0, 2'd0, 9'h055, 10, 16'h02AA, 16'h0000, 4, 0, 40};
        vecs[1] = '{16'd4, 4'd8, 4'd8, 3'd0, 2'd0, 9'h0FF, 10, 16'h03FE, 16'h02AA, 4, 0, 45};
        vecs[2] = '{16'd1, 4'd0, 4'd8, 3'd0, 2'd0, 9'h00F, 10, 16'h021E, 16'h0000, 2, 0, 20};
        vecs[3] = '{16'd3, 4'd0, 4'd7, 3'd1, 2'd1, 9'h083, 11, 16'h0606, 16'h0000, 3, 0, 33};
        vecs[4] = '{16'd3, 4'd0, 4'd7, 3'd2, 2'd1, 9'h083, 11, 16'h0706, 16'h0000, 3, 0, 33};
        vecs[5] = '{16'd6, 4'd0, 4'd8, 3'd0, 2'd2, 9'h0A5, 11, 16'h074A, 16'h0000, 6, 3, 63};
        vecs[6] = '{16'd2, 4'd0, 4'd3, 3'd3, 2'd3, 9'h1F0, 8,  16'h00E0, 16'h0000, 2, 0, 16};
        vecs[7] = '{16'd2, 4'd0, 4'd15, 3'd4, 2'd0, 9'h1FF, 12, 16'h0BFE, 16'h0000, 2, 0, 24};
        vecs[8] = '{16'd2, 4'd0, 4'd8, 3'd6, 2'd0, 9'h001, 10, 16'h0202, 16'h0000, 2, 0, 20};
        vb2b    = '{16'd6, 4'd0, 4'd8, 3'd0, 2'd2, 9'h03C, 11, 16'h0678, 16'h0000, 6, 3, 63};
        vcts    = '{16'd4, 4'd0, 4'd8, 3'd0, 2'd0, 9'h012, 10, 16'h0224, 16'h0000, 4, 0, 40};

        rst = 1'b1; ctsn = 1'b0; break_req = 1'b0;
        s_axis_if.tdata = '0; s_axis_if.tvalid = 1'b0;
        set_cfg(vecs[0]);
        tick(); tick();
        chk("reset txd", 128'(txd), 128'(1));
        chk("reset tready", 128'(s_axis_if.tready), 128'(1));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset break_active", 128'(break_active), 128'(0));
        chk("reset frame_done", 128'(frame_done), 128'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            set_cfg(vecs[i]);
            send(vecs[i].data);
            capture(vecs[i].exp_len, w, tr, fd_at, fd_cnt, bz);
            chk($sformatf("v%0d wave", i), 128'(w), 128'(build_wave(vecs[i])));
            chk($sformatf("v%0d frame_done cycle", i), 128'(fd_at), 128'(vecs[i].exp_len));
            chk($sformatf("v%0d frame_done count", i), 128'(fd_cnt), 128'(1));
            chk($sformatf("v%0d busy in frame", i), 128'(bz), 128'(1));
            tick();
            chk($sformatf("v%0d idle after", i), 128'({busy, txd}), 128'(2'b01));
        end

        // Back-to-back: second beat waits in the holding register.
        set_cfg(vecs[5]);
        s_axis_if.tdata  = 9'h0A5;
        s_axis_if.tvalid = 1'b1;
        tick();
        s_axis_if.tdata  = 9'h03C;
        tick(); a1_txd = txd; a1_tr = s_axis_if.tready;
        tick(); a2_txd = txd; a2_tr = s_axis_if.tready;
        s_axis_if.tvalid = 1'b0;
        capture(61, wa, tra, fd_at, fd_cnt, bz);
        chk("b2b A wave", 128'((wa << 2) | {62'd0, a2_txd, a1_txd}), 128'(build_wave(vecs[5])));
        chk("b2b A tready", 128'((tra << 2) | {62'd0, a2_tr, a1_tr}), 128'(64'h1));
        chk("b2b A frame_done cycle", 128'(fd_at + 2), 128'(63));
        capture(63, w, tr, fd_at, fd_cnt, bz);
        chk("b2b B wave", 128'(w), 128'(build_wave(vb2b)));
        chk("b2b B tready", 128'(tr), 128'(64'h7FFF_FFFF_FFFF_FFFF));
        chk("b2b B frame_done cycle", 128'(fd_at), 128'(63));
        chk("b2b B busy", 128'(bz), 128'(1));
        tick();
        chk("b2b idle after", 128'({busy, txd}), 128'(2'b01));

        // Clear-to-send gating, then mid-frame ctsn/config changes are ignored.
        set_cfg(vcts);
        ctsn = 1'b1;
        send(9'h012);
        repeat (5) tick();
        chk("ctsn blocked txd/busy/tready", 128'({txd, busy, s_axis_if.tready}), 128'(3'b100));
        ctsn = 1'b0;
        tick();
        chk("ctsn release start bit", 128'(txd), 128'(0));
        ctsn = 1'b1;
        prescaler_config = 16'd9;
        capture(39, w, tr, fd_at, fd_cnt, bz);
        chk("ctsn frame wave", 128'(w), 128'(build_wave(vcts) >> 1));
        chk("ctsn frame_done cycle", 128'(fd_at), 128'(39));
        ctsn = 1'b0;
        set_cfg(vcts);
        tick();
        chk("ctsn idle after", 128'({busy, txd}), 128'(2'b01));

        // Break requested mid-frame: frame, one idle cycle, break, mark bit, idle.
        send(9'h000);
        a_txd = '0; e_txd = '0; a_brk = '0; e_brk = '0;
        a_busy = '0; e_busy = '0; a_fd = '0; e_fd = '0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            a_txd[i]  = txd;
            a_brk[i]  = break_active;
            a_busy[i] = busy;
            a_fd[i]   = frame_done;
            e_txd[i]  = !((i <= 36) || (i >= 42 && i <= 60));
            e_brk[i]  = (i >= 42 && i <= 60);
            e_busy[i] = (i <= 40) || (i >= 42 && i <= 64);
            e_fd[i]   = (i == 40);
            if (i == 10) break_req = 1'b1;
            if (i == 60) break_req = 1'b0;
        end
        chk("break txd", a_txd, e_txd);
        chk("break break_active", a_brk, e_brk);
        chk("break busy", a_busy, e_busy);
        chk("break frame_done", a_fd, e_fd);

        // Asynchronous reset with both shift and holding registers full.
        send(9'h05A);
        s_axis_if.tdata  = 9'h033;
        s_axis_if.tvalid = 1'b1;
        tick(); tick();
        s_axis_if.tvalid = 1'b0;
        repeat (5) tick();
        chk("pre-reset tready", 128'(s_axis_if.tready), 128'(0));
        #1 rst = 1'b1;
        #1;
        chk("async reset txd", 128'(txd), 128'(1));
        chk("async reset tready", 128'(s_axis_if.tready), 128'(1));
        chk("async reset busy", 128'(busy), 128'(0));
        tick();
        rst = 1'b0;
        stayed_idle = 1'b1;
        repeat (10) begin
            tick();
            if (busy || !txd || !s_axis_if.tready) stayed_idle = 1'b0;
        end
        chk("words discarded by reset", 128'(stayed_idle), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_frac.md
Name: uart_tx_frac

Overview:
Next-generation UART transmitter for the axis_uart core. It takes words from an AXI-Stream slave and serialises them on txd. It adds:
- a runtime word length (5..MAX_WORD_SIZE)
- a fractional baud divider
- 1, 1.5 or 2 stop bits
- double buffering, so back-to-back frames leave no idle gap
- break generation and a per-frame completion pulse

It sits between the AXI-Stream TX FIFO and the IOB output flop.

Parameters:
MAX_WORD_SIZE, 9, width of s_axis_tdata and maximum runtime word length (range 5..9)
RESET_PRESCALER, 12, integer bit period in aclk cycles used until first config latch

Ports:
aclk  input  1  clock
rst  input  1  asynchronous active-high reset
s_axis_tdata  input  MAX_WORD_SIZE  word to send, LSB first; bits at or above word_size_config are ignored
s_axis_tvalid  input  1  AXI-Stream valid
s_axis_tready  output  1  high while the holding register is empty
txd  output  1  serial output, registered, idle high
ctsn  input  1  clear-to-send, active low, sampled only at frame start
break_req  input  1  request a line break
break_active  output  1  high while in BREAK state
busy  output  1  high whenever state is not IDLE
frame_done  output  1  one-cycle pulse in the last cycle of each stop period
prescaler_config  input  16  integer bit period P; values below 2 are treated as 2
frac_config  input  4  fractional bit period F/16
word_size_config  input  4  data bits; clamped to the range 5..MAX_WORD_SIZE
parity_config  input  3  0 none, 1 even, 2 odd, 3 mark, 4 space; values 5-7 are treated as none
stop_bits_config  input  2  0 one, 1 two, 2 one-and-a-half; value 3 is treated as one

Behaviour:
- Reset (async, rst high):
  - state=IDLE, txd=1, s_axis_tready=1, busy=0, break_active=0, frame_done=0.
  - Holding register empty, fraction accumulator 0.
  - Latched config = RESET_PRESCALER, F=0, 8 bits, no parity, one stop bit.
  - Asserting rst mid-frame forces txd=1 immediately; the in-flight and holding words are discarded.
- Holding register:
  - Accepted on any edge where s_axis_tvalid & s_axis_tready.
  - s_axis_tready = ~hold_valid.
  - The holding register empties on the edge where its word moves to the shift register.
- Configuration: all *_config inputs are latched on the edge that enters START (every frame, including back-to-back frames). They are ignored mid-frame.
- Bit timing:
  - At each bit start, {carry, acc} = acc + F; the bit lasts P + carry cycles.
  - acc is cleared at every START entry.
  - A half stop bit lasts P>>1 cycles and does not step the accumulator.
- FSM:
  - IDLE (txd=1):
    - break_req=1 -> BREAK. Break takes priority over pending data.
    - Otherwise, hold_valid & ~ctsn -> START. This loads the shift register and latches config.
    - ctsn high blocks the start; the word stays held.
  - START (txd=0, one bit period) -> DATA.
  - DATA: txd = shift[0]; shift right once per bit period; after word_size bits -> PAR if parity enabled, else STOP.
  - PAR (txd = parity bit, one bit period) -> STOP.
    - even: XOR of the data bits.
    - odd: XNOR of the data bits.
    - mark: 1.
    - space: 0.
  - STOP (txd=1):
    - Length is 1, 2 or 1.5 bit periods per the latched stop-bit setting.
    - frame_done pulses in the final cycle.
    - At the end: if ~break_req & hold_valid & ~ctsn -> START directly (zero gap); otherwise -> IDLE.
  - BREAK (txd=0, break_active=1):
    - Held while break_req=1, for a minimum of one bit period.
    - On deassert -> STOP for one bit period (mark after break, no frame_done pulse) -> IDLE.
    - break_req asserted mid-frame takes effect only after the current frame's stop bits.
- Latency: txd falls exactly 1 cycle after the accepting handshake edge when starting from IDLE with ctsn low.
- ctsn changes mid-frame are ignored. A new s_axis beat may be accepted during any state while the holding register is empty.

Test Plan:
1. P=4, F=0, 8N1; send 0x55 from IDLE -> txd from the cycle after the handshake: 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop 1 for 4 cycles. Frame is 40 cycles, frame_done on cycle 40, busy high throughout.
2. P=4, F=8, 8N1; send 0xFF -> bit lengths 4,5,4,5,... and the frame totals 45 cycles. Then F=0, P=1 -> bits last 2 cycles (clamp).
3. Word size 7, even parity, two stop bits, P=3; send 0x83 -> data bits 1,1,0,0,0,0,0 (bit 7 ignored), parity 0, stop high for 6 cycles, frame 33 cycles. Repeat with odd parity -> parity bit 1.
4. Two beats 0xA5, 0x3C with tvalid held; 1.5 stop, P=6 -> stop lasts 9 cycles, and the second start bit follows the first frame's stop with no idle cycle. s_axis_tready drops while both shift and holding registers are full.
5. ctsn=1, send 0x12 -> txd stays 1, busy=0, tready=0. Drop ctsn -> txd low 1 cycle later. Raise ctsn mid-frame -> frame completes unchanged.
6. Assert break_req mid-frame, hold for 50 cycles, P=4 -> the frame completes, then txd is low while break_active=1, then high for 4 cycles, then IDLE. Assert rst mid-frame -> txd=1 and tready=1 asynchronously.
